div_11_reconstruct: RTL
=======================

Name: div_11_reconstruct

Overview:
- Inverse of the constant-11 divider.
- Takes a quotient/remainder pair (Q, R) and rebuilds the dividend as X = 11*Q + R.
- Used in the same datapath to check divider results, and as the encode side when packed (Q, R) pairs are expanded back to 64-bit operands.
- 3-stage valid/ready pipeline, registered inputs and outputs, with overflow and illegal-remainder flags.

Parameters:
- X_W, 64: reconstructed dividend width.
- Q_W, 61: quotient width.
- R_W, 4: remainder width.
- DIVISOR, 11: constant multiplier. Fixed at 11 for this block; any other value is a synthesis-time error.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  Q_in/R_in valid.
- in_ready  out  1  block accepts input this cycle.
- Q_in  in  Q_W  quotient.
- R_in  in  R_W  remainder.
- out_valid  out  1  X_out and flags valid.
- out_ready  in  1  downstream accepts output.
- X_out  out  X_W  11*Q + R, modulo 2^X_W.
- ovf  out  1  true result did not fit in X_W bits.
- r_err  out  1  R_in >= DIVISOR (pair not canonical).

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0; all data/flag registers 0; out_valid=0, X_out=0, ovf=0, r_err=0. in_ready=1 from the first cycle after reset release.
- Transfer rule: input accepted when in_valid & in_ready at a rising edge; output consumed when out_valid & out_ready.
- Stage S1 (input register): captures Q_in, R_in and sets v1.
- Stage S2, from S1:
  - A = (Q<<3) + (Q<<1), computed at Q_W+4 bits.
  - B = Q + R, computed at Q_W+1 bits.
  - e = (R > DIVISOR-1).
  - Sets v2.
- Stage S3 (output register), from S2:
  - S = A + B at Q_W+4 = 65 bits.
  - X_out = S[X_W-1:0], ovf = |S[64:X_W], r_err = e.
  - Sets v3; out_valid = v3.
- Latency: 3 cycles from acceptance to out_valid with out_ready held high. Throughput 1 per cycle.
- Stall, bubble-collapsing:
  - adv3 = !v3 | out_ready
  - adv2 = !v2 | adv3
  - adv1 = !v1 | adv2
  - in_ready = adv1
  - A stage loads only when its adv is high; otherwise it holds data and valid.
  - The valid of a stage that advances with no incoming data clears to 0.
- Data/flags are stable while out_valid=1 and out_ready=0. Outputs never change without a handshake.
- Capacity: 3 items in flight. With out_ready low and all three stages full, in_ready=0 combinationally.
- Simultaneous accept and consume at full occupancy: both occur in the same cycle, with no bubble and no loss.
- Ordering is strictly FIFO. No item is dropped or duplicated.
- r_err and ovf are informational only. X_out is still 11*Q+R mod 2^64 in both cases, and both may assert together.
- Reset mid-operation discards all in-flight items. No output is produced for them after release.
- Inputs with in_valid=0 are ignored and never alter stage registers.
- Boundary:
  - Max Q (2^61-1) with R=15 yields S < 2^65; the 65-bit internal sum never wraps.
  - Largest non-overflowing pair: Q=0x1745D1745D1745D1, R=4, giving X_out=2^64-1.

Test Plan:
- Reset then Q=0, R=0 -> X_out=0, ovf=0, r_err=0, out_valid exactly 3 cycles after accept; in_ready=1 throughout.
- Q=5, R=3, then Q=0x1745D1745D1745D1, R=4, back-to-back -> X_out=58, then X_out=0xFFFFFFFFFFFFFFFF, both ovf=0, on consecutive cycles.
- Q=0x1745D1745D1745D2, R=0 -> X_out=6, ovf=1, r_err=0. Q=2^61-1, R=15 -> ovf=1.
- Q=7, R=11 -> X_out=88, r_err=1, ovf=0. R=10 -> r_err=0.
- Backpressure: out_ready=0 for 6 cycles while offering Q=1..5 (R=0) each cycle:
  - only 3 accepted, then in_ready=0;
  - out_valid holds X_out=11 stable;
  - after out_ready=1, outputs 11, 22, 33, 44, 55 arrive in order with no gaps.
- Assert rst_n low for 1 cycle with 2 items in flight -> out_valid=0 and X_out=0 immediately (asynchronous); no stale outputs after release; next accepted item emerges 3 cycles later.

Source files
------------

// File: rtl/div_11_reconstruct.sv
// Rebuilds a dividend from a constant-11 quotient/remainder pair: X = 11*Q + R.
// Three-register valid/ready pipeline with bubble collapsing, plus overflow and non-canonical-remainder flags.
module div_11_reconstruct #(
    parameter int X_W     = 64,
    parameter int Q_W     = 61,
    parameter int R_W     = 4,
    parameter int DIVISOR = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] Q_in,
    input  logic [R_W-1:0] R_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] X_out,
    output logic           ovf,
    output logic           r_err
);

    // 11*Q + 15 < 16*2^Q_W, so Q_W+4 bits hold the exact sum without wrapping.
    localparam int S_W = Q_W + 4;
    localparam logic [R_W-1:0] R_MAX = R_W'(DIVISOR - 1);

    generate
        if (DIVISOR != 11) begin : g_bad_divisor
            $error("div_11_reconstruct only supports DIVISOR = 11");
        end
        if (S_W <= X_W) begin : g_bad_width
            $error("div_11_reconstruct requires Q_W + 4 > X_W");
        end
    endgenerate

    logic           v1;
    logic           v2;
    logic           v3;
    logic           adv1;
    logic           adv2;
    logic           adv3;

    logic [Q_W-1:0] q1;
    logic [R_W-1:0] r1;

    logic [S_W-1:0] a2;
    logic [Q_W:0]   b2;
    logic           e2;

    logic [S_W-1:0] sum;
    logic [X_W-1:0] x3;
    logic           ovf3;
    logic           rerr3;

    // A stage may load whenever it is empty or the stage ahead of it is moving.
    assign adv3     = !v3 || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            q1 <= '0;
            r1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                q1 <= Q_in;
                r1 <= R_in;
            end
        end
    end

    // 11*Q is split as 10*Q + Q so the final add folds in the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            a2 <= '0;
            b2 <= '0;
            e2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                a2 <= (S_W'(q1) << 3) + (S_W'(q1) << 1);
                b2 <= (Q_W + 1)'(q1) + (Q_W + 1)'(r1);
                e2 <= (r1 > R_MAX);
            end
        end
    end

    assign sum = a2 + S_W'(b2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            x3    <= '0;
            ovf3  <= 1'b0;
            rerr3 <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                x3    <= sum[X_W-1:0];
                ovf3  <= |sum[S_W-1:X_W];
                rerr3 <= e2;
            end
        end
    end

    assign out_valid = v3;
    assign X_out     = x3;
    assign ovf       = ovf3;
    assign r_err     = rerr3;

endmodule
